// File: rtl/calc_pkg.sv
// Shared calculator constants: datapath widths, BCD adjust constants and the
// converter state encoding.
package calc_pkg;

  localparam int CALC_WIDTH  = 18;
  localparam int CALC_DIGITS = 6;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_INC    = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-add-3 step: digits of 5 or more get 3 added so
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_INC : din;

endmodule

// File: rtl/calc_bcd_conv.sv
// Sign-magnitude to packed BCD converter, one magnitude bit per clock.
// Build option CALC_BCD_BLANK_EN enables the leading-zero blank mask.
module calc_bcd_conv
  import calc_pkg::*;
#(
  parameter int WIDTH  = CALC_WIDTH,
  parameter int DIGITS = CALC_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int MAG_W = WIDTH - 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [MAG_W-1:0]   mag;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   work_adj;
  logic [CNT_W-1:0]   count;
  logic               sign_nz;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (work[4*gi +: 4]),
        .dout (work_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mag     <= '0;
      work    <= '0;
      count   <= '0;
      sign_nz <= 1'b0;
      done    <= 1'b0;
      neg     <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Negative zero is folded into a positive result here.
            sign_nz <= bin_in[WIDTH-1] & (|bin_in[MAG_W-1:0]);
            mag     <= bin_in[MAG_W-1:0];
            work    <= '0;
            count   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {work, mag} <= {work_adj, mag} << 1;
          count       <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 2)) state <= FINISH;
        end
        FINISH: begin
          bcd   <= work;
          neg   <= sign_nz;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              upper_zero;

  // Walk down from the top digit; digit 0 is never blanked.
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (work[4*i +: 4] == 4'd0);
      blank_next[i] = upper_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= '0;
    end else if (state == FINISH) begin
      blank <= blank_next;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_calc_bcd_conv.sv
// Self-checking bench for calc_bcd_conv: directed handshake scenarios plus
// randomized values checked against a decimal-arithmetic reference model.
module tb_calc_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [17:0] bin_in = '0;
  logic        busy, done, neg;
  logic [23:0] bcd;
  logic [5:0]  blank;

  int n_vec = 0;
  int n_err = 0;

  calc_bcd_conv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .neg    (neg),
    .bcd    (bcd),
    .blank  (blank)
  );

  always #5 clk = ~clk;

  // Reference model: decimal digits by division, sign folded for zero.
  function automatic logic [23:0] ref_bcd(input logic [17:0] v);
    int m = int'(v[16:0]);
    int p = 1;
    logic [23:0] r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'((m / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic ref_neg(input logic [17:0] v);
    return v[17] && (v[16:0] != 17'd0);
  endfunction

  function automatic logic [5:0] ref_blank(input logic [17:0] v);
    logic [5:0] b = '0;
`ifdef CALC_BCD_BLANK_EN
    int m = int'(v[16:0]);
    int p = 10;
    for (int i = 1; i < 6; i++) begin
      b[i] = (m < p);
      p = p * 10;
    end
`endif
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is held for exactly one edge; bin_in is scrambled afterwards.
  task automatic launch(input logic [17:0] v);
    start  = 1'b1;
    bin_in = v;
    tick();
    start  = 1'b0;
    bin_in = 18'($urandom);
  endtask

  // Returns edges from the start edge to the first done, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within 40 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({busy, done, neg, bcd, blank} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", {busy, done, neg, bcd, blank});
    end
    $display("reset: busy=%b done=%b bcd=%h", busy, done, bcd);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_max();
    int lat;
    launch(18'h1FFFF);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL max_busy: got %b want 1", busy);
    end
    wait_done(lat);
    n_vec++;
    if (lat != 18) begin
      n_err++;
      $display("FAIL max_latency: got %0d want 18", lat);
    end
    n_vec++;
    if (bcd !== 24'h131071 || neg !== 1'b0) begin
      n_err++;
      $display("FAIL max_value: got neg=%b bcd=%h want neg=0 bcd=131071", neg, bcd);
    end
    n_vec++;
    if (blank !== ref_blank(18'h1FFFF)) begin
      n_err++;
      $display("FAIL max_blank: got %b want %b", blank, ref_blank(18'h1FFFF));
    end
    $display("max: lat=%0d neg=%b bcd=%h blank=%b", lat, neg, bcd, blank);
  endtask

  task automatic test_fixed();
    logic [17:0] vin  [2] = '{{1'b1, 17'd12345}, {1'b1, 17'd0}};
    logic [23:0] vbcd [2] = '{24'h012345, 24'h000000};
    logic        vneg [2] = '{1'b1, 1'b0};
`ifdef CALC_BCD_BLANK_EN
    logic [5:0]  vblk [2] = '{6'b100000, 6'b111110};
`else
    logic [5:0]  vblk [2] = '{6'b000000, 6'b000000};
`endif
    int lat;
    for (int k = 0; k < 2; k++) begin
      launch(vin[k]);
      wait_done(lat);
      n_vec++;
      if (bcd !== vbcd[k] || neg !== vneg[k]) begin
        n_err++;
        $display("FAIL fixed_value[%0d]: got neg=%b bcd=%h want neg=%b bcd=%h",
                 k, neg, bcd, vneg[k], vbcd[k]);
      end
      n_vec++;
      if (blank !== vblk[k]) begin
        n_err++;
        $display("FAIL fixed_blank[%0d]: got %b want %b", k, blank, vblk[k]);
      end
      $display("fixed[%0d]: in=%h neg=%b bcd=%h blank=%b", k, vin[k], neg, bcd, blank);
    end
  endtask

  task automatic test_random();
    logic [17:0] v;
    logic [23:0] held;
    int lat;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(3))
        0: v = {1'($urandom), 17'($urandom_range(9))};
        1: v = {1'($urandom), 17'($urandom_range(999))};
        default: v = 18'($urandom);
      endcase
      launch(v);
      wait_done(lat);
      n_vec++;
      if (lat != 18 || bcd !== ref_bcd(v) || neg !== ref_neg(v) || blank !== ref_blank(v)) begin
        n_err++;
        $display("FAIL rand[%0d]: in=%h got lat=%0d neg=%b bcd=%h blank=%b want lat=18 neg=%b bcd=%h blank=%b",
                 k, v, lat, neg, bcd, blank, ref_neg(v), ref_bcd(v), ref_blank(v));
      end
      held = bcd;
      tick();
      tick();
      n_vec++;
      if (bcd !== held || done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rand_hold[%0d]: got bcd=%h done=%b busy=%b want bcd=%h done=0 busy=0",
                 k, bcd, done, busy, held);
      end
      $display("rand[%0d]: in=%h neg=%b bcd=%h blank=%b", k, v, neg, bcd, blank);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int n_done = 0;
    launch(18'd42);
    repeat (3) tick();
    start  = 1'b1;
    bin_in = 18'd999;
    tick();
    start  = 1'b0;
    wait_done(lat);
    n_vec++;
    if (bcd !== 24'h000042) begin
      n_err++;
      $display("FAIL busy_ignore_value: got %h want 000042", bcd);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_ignore_fall: got busy=%b done=%b want 0 0", busy, done);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin
      n_err++;
      $display("FAIL busy_ignore_extra: got %0d extra done pulses want 0", n_done);
    end
    $display("busy_ignore: bcd=%h extra_done=%0d", bcd, n_done);
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(18'd7);
    wait_done(lat);
    n_vec++;
    if (bcd !== 24'h000007) begin
      n_err++;
      $display("FAIL b2b_first: got %h want 000007", bcd);
    end
    start  = 1'b1;
    bin_in = 18'd100;
    tick();
    start  = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    wait_done(lat);
    n_vec++;
    if (lat != 18 || bcd !== 24'h000100) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d bcd=%h want lat=18 bcd=000100", lat, bcd);
    end
    $display("back_to_back: lat=%0d bcd=%h", lat, bcd);
  endtask

  task automatic test_reset_mid();
    int lat;
    int n_done = 0;
    launch(18'd55555);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, neg, bcd, blank} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_mid_state: got %h want 0", {busy, done, neg, bcd, blank});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got %0d busy/done cycles want 0", n_done);
    end
    launch(18'd3);
    wait_done(lat);
    n_vec++;
    if (bcd !== 24'h000003 || neg !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_rerun: got neg=%b bcd=%h want neg=0 bcd=000003", neg, bcd);
    end
    $display("reset_mid: quiet_violations=%0d bcd=%h", n_done, bcd);
  endtask

  initial begin
    test_reset();
    test_max();
    test_fixed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
